// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: type codes, opcodes,
// error codes and the per-type opcode legality table.
package inst_encoder_pkg;

  // Type codes match those produced by the opcode-to-type decoder.
  typedef enum logic [2:0] {
    IT_NULL = 3'd0,
    IT_R    = 3'd1,
    IT_I    = 3'd2,
    IT_S    = 3'd3,
    IT_B    = 3'd4,
    IT_U    = 3'd5,
    IT_J    = 3'd6
  } itype_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_NULL   = 2'd1,
    ERR_ALIGN  = 2'd2,
    ERR_OPCODE = 2'd3
  } err_e;

  function automatic logic opcode_legal(input logic [2:0] itype, input logic [6:0] opcode);
    logic ok;
    ok = 1'b0;
    case (itype)
      IT_R:    ok = (opcode == OP_OP);
      IT_I:    ok = (opcode == OP_IMM) || (opcode == OP_JALR) || (opcode == OP_LOAD);
      IT_S:    ok = (opcode == OP_STORE);
      IT_B:    ok = (opcode == OP_BRANCH);
      IT_U:    ok = (opcode == OP_LUI) || (opcode == OP_AUIPC);
      IT_J:    ok = (opcode == OP_JAL);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I field packer: instruction type plus fields -> 32-bit word.
// Types without an encoding produce an all-zero word.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  itype,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst
);

  // imm[0] is never encoded; B/J alignment is checked by the caller.
  logic unused_imm0;
  assign unused_imm0 = imm[0];

  always_comb begin
    inst = '0;
    case (itype)
      IT_R: inst = {funct7, rs2, rs1, funct3, rd, opcode};
      IT_I: inst = {imm[11:0], rs1, funct3, rd, opcode};
      IT_S: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IT_B: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IT_U: inst = {imm[31:12], rd, opcode};
      IT_J: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: inst = '0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: packs request fields into instruction words and
// emits them with sequential byte addresses through a 2-entry output FIFO.
// Define INST_ENCODER_CHECK_EN to drop requests whose opcode does not fit the type.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_itype,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [1:0]  err_code
);

  logic [31:0] word;
  logic [31:0] inst_mem [2];
  logic [31:0] addr_mem [2];
  logic [1:0]  count;
  logic        rd_ptr, wr_ptr;
  logic [31:0] addr_cnt;
  err_e        drop_code, err_code_q;
  logic        accept, drop, push, pop;

  inst_pack u_pack (
    .itype  (in_itype),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .inst   (word)
  );

  // Priority: bad type, then misaligned branch/jump target, then opcode.
  always_comb begin
    drop_code = ERR_NONE;
    if (in_itype == IT_NULL || in_itype > IT_J)
      drop_code = ERR_NULL;
    else if ((in_itype == IT_B || in_itype == IT_J) && in_imm[0])
      drop_code = ERR_ALIGN;
`ifdef INST_ENCODER_CHECK_EN
    else if (!opcode_legal(in_itype, in_opcode))
      drop_code = ERR_OPCODE;
`endif
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign drop      = (drop_code != ERR_NONE);
  assign push      = accept && !drop;
  assign pop       = out_valid && out_ready;

  // The empty buffer shows zero data and the next address to be assigned.
  assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_addr = out_valid ? addr_mem[rd_ptr] : addr_cnt;
  assign err_code = err_code_q;

  // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= word;
      addr_mem[wr_ptr] <= addr_cnt;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      addr_cnt   <= BASE_ADDR;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        addr_cnt <= addr_cnt + ADDR_STEP;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      err <= accept && drop;
      if (accept && drop) err_code_q <= drop_code;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, addressing,
// back-pressure, drop errors and mid-transfer reset.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_itype;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst, out_addr;
  logic        err;
  logic [1:0]  err_code;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_itype  (in_itype),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err       (err),
    .err_code  (err_code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic req(input logic [2:0] itype, input logic [6:0] opcode, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_itype  = itype;
    in_opcode = opcode;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    req(IT_NULL, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_addr", out_addr, 32'h8000_0000);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_in_ready", in_ready, 1);

    // addi x1,x0,5
    req(IT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick(); in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_inst", out_inst, 32'h0050_0093);
    check("addi_addr", out_addr, 32'h8000_0000);
    tick();
    check("addi_popped", out_valid, 0);

    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // add x3,x1,x2 then sw x2,8(x1) back-to-back
    req(IT_R, OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    check("add_inst", out_inst, 32'h0020_81B3);
    check("add_addr", out_addr, 32'h8000_0000);
    req(IT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    check("sw_inst", out_inst, 32'h0020_A423);
    check("sw_addr", out_addr, 32'h8000_0004);
    in_valid = 1'b0; tick();
    check("sw_popped", out_valid, 0);

    // beq x0,x0,-4 ; jal x1,8 ; lui x5,0x12345
    req(IT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1FFC);
    tick();
    check("beq_inst", out_inst, 32'hFE00_0EE3);
    check("beq_addr", out_addr, 32'h8000_0008);
    req(IT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    check("jal_inst", out_inst, 32'h0080_00EF);
    check("jal_addr", out_addr, 32'h8000_000C);
    req(IT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    check("lui_inst", out_inst, 32'h1234_52B7);
    check("lui_addr", out_addr, 32'h8000_0010);
    in_valid = 1'b0; tick();

    // Back-pressure: three requests, two fit; upper imm bits truncated on A.
    out_ready = 1'b0;
    req(IT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678);
    tick();
    check("stall_a_inst", out_inst, 32'h6780_0093);
    check("stall_a_addr", out_addr, 32'h8000_0014);
    check("stall_ready1", in_ready, 1);
    req(IT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    tick();
    check("stall_full", in_ready, 0);
    check("stall_hold_inst", out_inst, 32'h6780_0093);
    req(IT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    check("stall_still_full", in_ready, 0);
    check("stall_hold_inst2", out_inst, 32'h6780_0093);
    check("stall_hold_addr", out_addr, 32'h8000_0014);
    out_ready = 1'b1;
    tick();
    check("stall_b_inst", out_inst, 32'h8000_0113);
    check("stall_b_addr", out_addr, 32'h8000_0018);
    check("stall_ready2", in_ready, 1);
    tick();
    check("stall_c_inst", out_inst, 32'h0010_0193);
    check("stall_c_addr", out_addr, 32'h8000_001C);
    in_valid = 1'b0; tick();
    check("stall_drained", out_valid, 0);

    // Drops: NULL type, then misaligned jal.
    req(IT_NULL, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    check("null_err", err, 1);
    check("null_code", err_code, 1);
    check("null_no_out", out_valid, 0);
    req(IT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    check("jal3_err", err, 1);
    check("jal3_code", err_code, 2);
    check("jal3_no_out", out_valid, 0);
    in_valid = 1'b0; tick();
    check("err_pulse_end", err, 0);
    check("err_code_hold", err_code, 2);
    req(IT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    check("post_err_inst", out_inst, 32'h0000_0293);
    check("post_err_addr", out_addr, 32'h8000_0020);
    in_valid = 1'b0; tick();

    // R type carrying an I opcode.
    req(IT_R, OP_IMM, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
`ifdef INST_ENCODER_CHECK_EN
    check("opc_err", err, 1);
    check("opc_code", err_code, 3);
    check("opc_no_out", out_valid, 0);
`else
    check("opc_no_err", err, 0);
    check("opc_inst", out_inst, 32'h0020_8193);
    check("opc_addr", out_addr, 32'h8000_0024);
`endif
    in_valid = 1'b0; tick();

    // Reset with two words buffered discards them.
    out_ready = 1'b0;
    req(IT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    tick(); tick();
    in_valid = 1'b0;
    check("pre_rst_full", in_ready, 0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_addr", out_addr, 32'h8000_0000);
    check("mid_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    req(IT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    check("after_rst_inst", out_inst, 32'h0050_0093);
    check("after_rst_addr", out_addr, 32'h8000_0000);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
